harmonic_dft: RTL and testbench
===============================

// Module: harmonic_dft
// PURPOSE
//  Downstream of the 32-sample serial-in/parallel-out capture stage in the THDi chain.
//  On a start pulse (driven by the capture stage's done), latches the 32 signed samples.
//  Computes DFT bins h=1..NUM_HARM serially with one complex MAC per cycle.
//  Streams |X[h]|^2 per harmonic over valid/ready to the THD ratio stage.
// PARAMETERS
//  NUM_HARM  7   harmonics computed (1..NUM_HARM); legal range 1..15
//  ACC_W     38  accumulator width, signed; >= 37 needed for 32 x (16b*16b) terms
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  start      in   1    1-cycle pulse: frame ready; ignored unless state==IDLE
//  samples    in   512  signed 16b samples; x[n] = samples[16n+15:16n], n=0 oldest
//  busy       out  1    high from cycle after accepted start until done pulse
//  out_valid  out  1    harmonic result valid
//  out_ready  in   1    downstream accepts when out_valid && out_ready
//  out_harm   out  4    harmonic index h of current result (1..NUM_HARM)
//  out_mag    out  48   unsigned |X[h]|^2 = re^2 + im^2
//  done       out  1    1-cycle pulse after the last harmonic is accepted
// BEHAVIOUR
//  Reset: state=IDLE; busy, out_valid, done = 0; out_harm, out_mag, accumulators = 0.
//  Reset mid-frame: aborts immediately; the partial frame is discarded with no output.
//  FSM: IDLE -> LOAD -> MAC -> MAG -> EMIT -> (MAC for next h | DONE) -> IDLE.
//   IDLE: on start, capture samples into an internal 32x16 register file; h=1.
//   LOAD: 1 cycle; clear acc_re/acc_im; n=0.
//   MAC: 32 cycles, n=0..31; idx=(h*n) mod 32 (5-bit wrap).
//     acc_re += x[n]*COS[idx]; acc_im -= x[n]*COS[(idx+24) mod 32] (i.e. -sin).
//   MAG: re = acc_re >>> 14, im = acc_im >>> 14 (arithmetic); each fits 24b signed.
//     out_mag = re*re + im*im, zero-extended to 48b; out_harm = h.
//   EMIT: out_valid=1; out_harm/out_mag held stable while out_ready=0 (no timeout).
//     On acceptance: if h==NUM_HARM go to DONE; else h++, clear accumulators, n=0, go to MAC.
//   DONE: done=1 for exactly 1 cycle; busy=0 in the same cycle; next state IDLE.
//  Twiddles: COS[i] = round(16384*cos(2*pi*i/32)), signed Q1.14; COS[0]=16384 exactly.
//  Latency: start -> first out_valid = 35 cycles; 34 cycles per further harmonic at out_ready=1.
//  start while not IDLE: ignored; captured samples unchanged.
//  start coincident with DONE: ignored (only accepted in IDLE).
//  samples is sampled only in the start-accept cycle; later changes have no effect.
//  No saturation is needed: |sum| <= 2^34 before the shift, so ACC_W=38 never overflows.
// STRUCTURE
//  thdi_pkg: N_SAMPLES=32, SAMPLE_W=16, TW_FRAC=14, MAG_W=48, FSM state enum.
//  One sub-module: harmonic_twiddle_rom, a 32-entry Q1.14 cosine table.
//    Combinational read, two read ports (cos idx, sin idx).
//  Top level holds the FSM, sample register file, n/h counters, MAC datapath and squarer.
// TESTING
//  Impulse: x[0]=16384, others 0, start -> 7 results h=1..7, each out_mag=268435456 (2^28);
//    done 1 cycle after the 7th is accepted.
//  Cosine: x[n]=round(8192*cos(2*pi*n/32)) -> h=1 out_mag within 0.1% of 2^34;
//    h=2..7 out_mag < 2^12.
//  DC: all x[n]=1000 -> all h out_mag < 2^10 (twiddle rounding residue only).
//  Backpressure: out_ready=0 for 10 cycles during h=3 -> out_valid, out_harm=3 and out_mag
//    held constant; sequence resumes h=4 with no loss or duplicates.
//  Re-trigger: start pulsed at MAC cycle 5 of h=2 -> ignored, results match the
//    undisturbed run; a second start after done yields a fresh frame.
//  Reset: rst asserted during EMIT of h=4 -> out_valid, busy, done drop asynchronously;
//    the next start gives a full h=1..NUM_HARM sequence.
//  Parameter: NUM_HARM=1 -> exactly one result (h=1), then done.

Source files
------------

// File: rtl/harmonic_dft_pkg.sv
// Shared constants and types for the harmonic DFT block of the THDi chain.
package harmonic_dft_pkg;

    localparam int N_SAMPLES = 32;   // frame length delivered by the capture stage
    localparam int SAMPLE_W  = 16;   // signed sample / twiddle width
    localparam int TW_FRAC   = 14;   // twiddles are Q1.14
    localparam int MAG_W     = 48;   // |X[h]|^2 output width
    localparam int RED_W     = 24;   // width of re/im after dropping the twiddle fraction
    localparam int IDX_W     = 5;    // log2(N_SAMPLES): sample counter and twiddle index
    localparam int HARM_W    = 4;    // harmonic index width (h = 1..15)

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_MAG,
        ST_EMIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/harmonic_dft_if.sv
// Frame-in / harmonic-power-out bus between the capture stage, the DFT and the THD ratio stage.
interface harmonic_dft_if;
    import harmonic_dft_pkg::*;

    logic                          start;
    logic [N_SAMPLES*SAMPLE_W-1:0] samples;
    logic                          busy;
    logic                          out_valid;
    logic                          out_ready;
    logic [HARM_W-1:0]             out_harm;
    logic [MAG_W-1:0]              out_mag;
    logic                          done;

    // Producer of frames / consumer of harmonic results.
    modport master (
        output start,
        output samples,
        output out_ready,
        input  busy,
        input  out_valid,
        input  out_harm,
        input  out_mag,
        input  done
    );

    // The DFT engine itself.
    modport slave (
        input  start,
        input  samples,
        input  out_ready,
        output busy,
        output out_valid,
        output out_harm,
        output out_mag,
        output done
    );

endinterface

// File: rtl/harmonic_dft_twiddle_rom.sv
// 32-entry Q1.14 cosine table, COS[i] = round(16384*cos(2*pi*i/32)),
// with two independent combinational read ports (cosine and sine lookups).
module harmonic_twiddle_rom
    import harmonic_dft_pkg::*;
(
    input  logic [IDX_W-1:0] cos_idx_i,
    input  logic [IDX_W-1:0] sin_idx_i,
    output sample_t          cos_o,
    output sample_t          sin_o
);

    function automatic sample_t cos_lut(input logic [IDX_W-1:0] i);
        case (i)
            5'd0:    cos_lut =  16'sd16384;
            5'd1:    cos_lut =  16'sd16069;
            5'd2:    cos_lut =  16'sd15137;
            5'd3:    cos_lut =  16'sd13623;
            5'd4:    cos_lut =  16'sd11585;
            5'd5:    cos_lut =  16'sd9102;
            5'd6:    cos_lut =  16'sd6270;
            5'd7:    cos_lut =  16'sd3196;
            5'd8:    cos_lut =  16'sd0;
            5'd9:    cos_lut = -16'sd3196;
            5'd10:   cos_lut = -16'sd6270;
            5'd11:   cos_lut = -16'sd9102;
            5'd12:   cos_lut = -16'sd11585;
            5'd13:   cos_lut = -16'sd13623;
            5'd14:   cos_lut = -16'sd15137;
            5'd15:   cos_lut = -16'sd16069;
            5'd16:   cos_lut = -16'sd16384;
            5'd17:   cos_lut = -16'sd16069;
            5'd18:   cos_lut = -16'sd15137;
            5'd19:   cos_lut = -16'sd13623;
            5'd20:   cos_lut = -16'sd11585;
            5'd21:   cos_lut = -16'sd9102;
            5'd22:   cos_lut = -16'sd6270;
            5'd23:   cos_lut = -16'sd3196;
            5'd24:   cos_lut =  16'sd0;
            5'd25:   cos_lut =  16'sd3196;
            5'd26:   cos_lut =  16'sd6270;
            5'd27:   cos_lut =  16'sd9102;
            5'd28:   cos_lut =  16'sd11585;
            5'd29:   cos_lut =  16'sd13623;
            5'd30:   cos_lut =  16'sd15137;
            5'd31:   cos_lut =  16'sd16069;
            default: cos_lut =  16'sd0;
        endcase
    endfunction

    assign cos_o = cos_lut(cos_idx_i);
    assign sin_o = cos_lut(sin_idx_i);

endmodule

// File: rtl/harmonic_dft.sv
// Serial 32-point DFT for harmonics 1..NUM_HARM: one complex MAC per cycle,
// then |X[h]|^2 handed downstream over valid/ready, one harmonic at a time.
module harmonic_dft
    import harmonic_dft_pkg::*;
#(
    parameter int NUM_HARM = 7,
    parameter int ACC_W    = 38
) (
    input  logic          clk,
    input  logic          rst,
    harmonic_dft_if.slave bus
);

    localparam logic [HARM_W-1:0] LAST_H   = HARM_W'(NUM_HARM);
    localparam logic [HARM_W-1:0] FIRST_H  = HARM_W'(1);
    localparam logic [IDX_W-1:0]  LAST_N   = IDX_W'(N_SAMPLES - 1);
    // cos(a + 3*pi/2) = sin(a): the sine lookup is the cosine table shifted by 24 entries
    localparam logic [IDX_W-1:0]  SIN_OFFS = IDX_W'(24);

    state_e                  state_q, state_d;
    logic [HARM_W-1:0]       h_q, h_d;
    logic [IDX_W-1:0]        n_q, n_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
    logic [HARM_W-1:0]       harm_q, harm_d;
    logic [MAG_W-1:0]        mag_q, mag_d;
    sample_t                 x_q [N_SAMPLES];

    logic                    start_acc;
    logic                    accept;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        sin_idx;
    sample_t                 x_cur;
    sample_t                 cos_v;
    sample_t                 sin_v;
    logic signed [2*SAMPLE_W-1:0] prod_re;
    logic signed [2*SAMPLE_W-1:0] prod_im;

    // Drop the Q1.14 twiddle fraction (floor) and form re^2 + im^2.
    // |acc| <= 2^34, so each shifted component fits 24 bits and the sum stays below 2^47.
    function automatic logic [MAG_W-1:0] power_of(input logic signed [ACC_W-1:0] re_acc,
                                                   input logic signed [ACC_W-1:0] im_acc);
        logic signed [RED_W-1:0] re_r;
        logic signed [RED_W-1:0] im_r;
        logic signed [MAG_W-1:0] re_w;
        logic signed [MAG_W-1:0] im_w;
        re_r = RED_W'(re_acc >>> TW_FRAC);
        im_r = RED_W'(im_acc >>> TW_FRAC);
        re_w = MAG_W'(re_r);
        im_w = MAG_W'(im_r);
        return $unsigned(re_w * re_w) + $unsigned(im_w * im_w);
    endfunction

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    assign accept    = (state_q == ST_EMIT) && bus.out_ready;

    // Twiddle index (h*n) mod 32 falls out of the 5-bit truncation of the product.
    assign idx     = IDX_W'(h_q) * n_q;
    assign sin_idx = idx + SIN_OFFS;
    assign x_cur   = x_q[n_q];

    harmonic_twiddle_rom u_rom (
        .cos_idx_i (idx),
        .sin_idx_i (sin_idx),
        .cos_o     (cos_v),
        .sin_o     (sin_v)
    );

    assign prod_re = x_cur * cos_v;
    assign prod_im = x_cur * sin_v;

    // Sample register file: loaded only when a start is accepted, never reset.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                x_q[i] <= bus.samples[SAMPLE_W*i +: SAMPLE_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: LOAD once per frame, then MAC/MAG/EMIT per harmonic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_MAC;
            ST_MAC:  if (n_q == LAST_N) state_d = ST_MAG;
            ST_MAG:  state_d = ST_EMIT;
            ST_EMIT: if (bus.out_ready) state_d = (h_q == LAST_H) ? ST_DONE : ST_MAC;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from state so a reset drops them without waiting for a clock.
    always_comb begin
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            ST_LOAD, ST_MAC, ST_MAG: bus.busy = 1'b1;
            ST_EMIT: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
            end
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state: counters, complex accumulators and the held result.
    always_comb begin
        h_d      = h_q;
        n_d      = n_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        harm_d   = harm_q;
        mag_d    = mag_q;
        case (state_q)
            ST_IDLE: if (start_acc) h_d = FIRST_H;
            ST_LOAD: begin
                acc_re_d = '0;
                acc_im_d = '0;
                n_d      = '0;
            end
            ST_MAC: begin
                acc_re_d = acc_re_q + ACC_W'(prod_re);
                acc_im_d = acc_im_q - ACC_W'(prod_im);
                n_d      = n_q + IDX_W'(1);
            end
            ST_MAG: begin
                mag_d  = power_of(acc_re_q, acc_im_q);
                harm_d = h_q;
            end
            ST_EMIT: begin
                if (accept && (h_q != LAST_H)) begin
                    h_d      = h_q + HARM_W'(1);
                    acc_re_d = '0;
                    acc_im_d = '0;
                    n_d      = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; a mid-frame reset discards the partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q      <= '0;
            n_q      <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            harm_q   <= '0;
            mag_q    <= '0;
        end else begin
            h_q      <= h_d;
            n_q      <= n_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            harm_q   <= harm_d;
            mag_q    <= mag_d;
        end
    end

    assign bus.out_harm = harm_q;
    assign bus.out_mag  = mag_q;

endmodule

// File: tb/tb_harmonic_dft.sv
// Directed bench for harmonic_dft: impulse, shifted impulse, DC, cosine, backpressure,
// re-trigger, mid-frame reset and a NUM_HARM=1 instance.
module tb_harmonic_dft;
    import harmonic_dft_pkg::*;

    localparam int K_IMP   = 0;   // x[0]=16384: every bin is 2^28
    localparam int K_SHIFT = 1;   // x[1]=16384: bin h is COS[h]^2 + COS[h+24]^2
    localparam int K_DC    = 2;   // all 1000: the table is antisymmetric, every bin is 0

    logic clk = 1'b0;
    logic rst;
    int   checks    = 0;
    int   failures  = 0;
    int   lat_first = 0;
    int   lat_next  = 0;

    logic [511:0] v_imp;
    logic [511:0] v_shift;
    logic [511:0] v_dc;
    logic [511:0] v_cos;

    harmonic_dft_if bus ();
    harmonic_dft_if bus1 ();

    always #5 clk = ~clk;

    harmonic_dft #(.NUM_HARM(7), .ACC_W(38)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    harmonic_dft #(.NUM_HARM(1), .ACC_W(38)) dut_h1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed |X[h]|^2 for the directed frames.
    function automatic logic [47:0] exp_mag(input int kind, input int h);
        if (kind == K_IMP) return 48'd268435456;
        if (kind == K_DC)  return 48'd0;
        case (h)
            1, 7:    return 48'd268427177;   // 16069^2 + 3196^2
            2, 6:    return 48'd268441669;   // 15137^2 + 6270^2
            3, 5:    return 48'd268432533;   // 13623^2 + 9102^2
            4:       return 48'd268424450;   // 2 * 11585^2
            default: return 48'd0;
        endcase
    endfunction

    task automatic pulse_start(input logic [511:0] smp);
        bus.samples = smp;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int t);
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        check_val({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic take(input string tag, input int kind, input int h, output int t);
        string nm;
        nm = $sformatf("%s_h%0d", tag, h);
        wait_valid(nm, t);
        check_val({nm, "_harm"}, 64'(bus.out_harm), 64'(h));
        check_val({nm, "_mag"}, 64'(bus.out_mag), 64'(exp_mag(kind, h)));
        tick();
    endtask

    task automatic finish_frame(input string tag);
        check_val({tag, "_done"}, 64'(bus.done), 64'd1);
        check_val({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        tick();
        check_val({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_frame(input string tag, input int kind, input logic [511:0] smp);
        int t;
        pulse_start(smp);
        check_val({tag, "_busy"}, 64'(bus.busy), 64'd1);
        for (int h = 1; h <= 7; h++) begin
            take(tag, kind, h, t);
            if (h == 1) lat_first = t + 1;
            if (h == 2) lat_next = t + 1;
        end
        finish_frame(tag);
    endtask

    initial begin
        int          t;
        int          v;
        int          seen;
        logic [47:0] m;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.samples    = '0;
        bus.out_ready  = 1'b1;
        bus1.start     = 1'b0;
        bus1.samples   = '0;
        bus1.out_ready = 1'b1;

        v_imp   = '0;
        v_shift = '0;
        v_imp[15:0]    = 16'h4000;
        v_shift[31:16] = 16'h4000;
        for (int n = 0; n < 32; n++) begin
            v_dc[16*n +: 16] = 16'd1000;
            v = int'(8192.0 * $cos(2.0 * 3.14159265358979 * n / 32.0));
            v_cos[16*n +: 16] = 16'(v);
        end

        // Reset state
        tick();
        tick();
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_harm", 64'(bus.out_harm), 64'd0);
        check_val("rst_mag", 64'(bus.out_mag), 64'd0);
        rst = 1'b0;
        tick();

        // Impulse and latency
        run_frame("imp", K_IMP, v_imp);
        check_val("lat_first", 64'(lat_first), 64'd35);
        check_val("lat_next", 64'(lat_next), 64'd34);

        // Shifted impulse exercises both twiddle ports per harmonic
        run_frame("shift", K_SHIFT, v_shift);

        // DC input
        run_frame("dc", K_DC, v_dc);

        // Cosine at bin 1
        pulse_start(v_cos);
        for (int h = 1; h <= 7; h++) begin
            wait_valid($sformatf("cos_h%0d", h), t);
            m = bus.out_mag;
            check_val($sformatf("cos_h%0d_harm", h), 64'(bus.out_harm), 64'(h));
            if (h == 1)
                check_val("cos_h1_near_2p34",
                          64'(m > 48'd17162689315 && m < 48'd17197049053), 64'd1);
            else
                check_val($sformatf("cos_h%0d_small", h), 64'(m < 48'd4096), 64'd1);
            tick();
        end
        finish_frame("cos");

        // Backpressure on h=3
        pulse_start(v_shift);
        take("bp", K_SHIFT, 1, t);
        take("bp", K_SHIFT, 2, t);
        bus.out_ready = 1'b0;
        wait_valid("bp_h3", t);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_val($sformatf("bp_hold%0d_valid", c), 64'(bus.out_valid), 64'd1);
            check_val($sformatf("bp_hold%0d_harm", c), 64'(bus.out_harm), 64'd3);
            check_val($sformatf("bp_hold%0d_mag", c), 64'(bus.out_mag), 64'(exp_mag(K_SHIFT, 3)));
        end
        bus.out_ready = 1'b1;
        tick();
        for (int h = 4; h <= 7; h++) take("bp", K_SHIFT, h, t);
        finish_frame("bp");

        // Start during MAC of h=2 with different samples is ignored
        pulse_start(v_shift);
        take("rt", K_SHIFT, 1, t);
        repeat (5) tick();
        bus.samples = v_imp;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        check_val("rt_busy", 64'(bus.busy), 64'd1);
        for (int h = 2; h <= 7; h++) take("rt", K_SHIFT, h, t);
        finish_frame("rt");
        run_frame("rt_fresh", K_IMP, v_imp);

        // Reset while h=4 is waiting in EMIT
        pulse_start(v_shift);
        for (int h = 1; h <= 3; h++) take("mrst", K_SHIFT, h, t);
        bus.out_ready = 1'b0;
        wait_valid("mrst_h4", t);
        check_val("mrst_h4_harm", 64'(bus.out_harm), 64'd4);
        #2;
        rst = 1'b1;
        #1;
        check_val("mrst_valid", 64'(bus.out_valid), 64'd0);
        check_val("mrst_busy", 64'(bus.busy), 64'd0);
        check_val("mrst_done", 64'(bus.done), 64'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check_val("mrst_idle_busy", 64'(bus.busy), 64'd0);
        check_val("mrst_idle_valid", 64'(bus.out_valid), 64'd0);
        run_frame("post_rst", K_SHIFT, v_shift);

        // NUM_HARM=1 instance; also a start coincident with DONE
        bus1.samples = v_imp;
        bus1.start   = 1'b1;
        tick();
        bus1.start   = 1'b0;
        check_val("nh1_busy", 64'(bus1.busy), 64'd1);
        t = 0;
        while (bus1.out_valid !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        check_val("nh1_valid", 64'(bus1.out_valid), 64'd1);
        check_val("nh1_lat", 64'(t + 1), 64'd35);
        check_val("nh1_harm", 64'(bus1.out_harm), 64'd1);
        check_val("nh1_mag", 64'(bus1.out_mag), 64'd268435456);
        tick();
        check_val("nh1_done", 64'(bus1.done), 64'd1);
        check_val("nh1_valid_at_done", 64'(bus1.out_valid), 64'd0);
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check_val("nh1_done_pulse", 64'(bus1.done), 64'd0);
        check_val("nh1_start_at_done_ignored", 64'(bus1.busy), 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus1.out_valid === 1'b1) seen++;
        end
        check_val("nh1_no_extra", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
